// File: rtl/dsp_pipe_pkg.sv
// Shared constants and helpers for the DSP48A1 pipeline register chain.
// Used by dsp_pipe_stage and dsp_pipe_chain.
package dsp_pipe_pkg;

  localparam int MAX_DEPTH = 4;
  localparam int MAX_WIDTH = 48;

  // Occupancy counter width: enough to hold 0..depth, never narrower than 1.
  function automatic int occ_w(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

  function automatic bit depth_ok(input int depth);
    return (depth >= 0) && (depth <= MAX_DEPTH);
  endfunction

  function automatic bit width_ok(input int width);
    return (width >= 1) && (width <= MAX_WIDTH);
  endfunction

endpackage

// File: rtl/dsp_pipe_stage.sv
// One pipeline slot: a valid flop plus a data register that loads only on valid.
// The data register holds across bubbles so the last valid sample stays visible.
module dsp_pipe_stage #(
  parameter int WIDTH = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             sclr,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (sclr) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (ce) begin
      out_valid <= in_valid;
      if (in_valid)
        out_data <= in_data;
    end
  end

endmodule

// File: rtl/dsp_pipe_chain.sv
// Depth-configurable register chain with per-stage valid, clock enable,
// synchronous clear and a registered occupancy counter.
module dsp_pipe_chain
  import dsp_pipe_pkg::*;
#(
  parameter  int WIDTH = 18,
  parameter  int DEPTH = 1,
  localparam int OCC_W = occ_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             sclr,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [OCC_W-1:0] occ
);

  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("dsp_pipe_chain: DEPTH out of range 0..%0d", MAX_DEPTH);
  end

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("dsp_pipe_chain: WIDTH out of range 1..%0d", MAX_WIDTH);
  end

  if (DEPTH == 0) begin : g_bypass
    assign out_valid = in_valid;
    assign out_data  = in_data;
    assign occ       = '0;
  end else begin : g_pipe
    logic [DEPTH-1:0] v;
    logic [WIDTH-1:0] d [DEPTH];
    logic [OCC_W-1:0] cnt;

    for (genvar i = 0; i < DEPTH; i++) begin : g_st
      logic             up_valid;
      logic [WIDTH-1:0] up_data;

      if (i == 0) begin : g_head
        assign up_valid = in_valid;
        assign up_data  = in_data;
      end else begin : g_link
        assign up_valid = v[i-1];
        assign up_data  = d[i-1];
      end

      dsp_pipe_stage #(
        .WIDTH(WIDTH)
      ) u_stage (
        .clk      (clk),
        .rst      (rst),
        .ce       (ce),
        .sclr     (sclr),
        .in_valid (up_valid),
        .in_data  (up_data),
        .out_valid(v[i]),
        .out_data (d[i])
      );
    end

    // Enter and leave in the same edge cancel; the chain can never overflow.
    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        cnt <= '0;
      else if (sclr)
        cnt <= '0;
      else if (ce)
        cnt <= cnt + OCC_W'(in_valid) - OCC_W'(v[DEPTH-1]);
    end

    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];
    assign occ       = cnt;

    a_occ : assert property (
      @(posedge clk) disable iff (rst)
        cnt == OCC_W'($countones(v))
    );
  end

endmodule

// File: tb/tb_dsp_pipe_chain.sv
// Scoreboard bench for dsp_pipe_chain at DEPTH 0, 2, 3 and 4 sharing one stimulus.
// Model: per build, the last DEPTH ce-edge samples plus the newest valid sample aged out.
module tb_dsp_pipe_chain;

  localparam int W = 18;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         ce = 1'b0;
  logic         sclr = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;

  logic         v0, v2, v3, v4;
  logic [W-1:0] d0, d2, d3, d4;
  logic [0:0]   o0;
  logic [1:0]   o2, o3;
  logic [2:0]   o4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dsp_pipe_chain #(.WIDTH(W), .DEPTH(0)) u_d0 (
    .clk(clk), .rst(rst), .ce(ce), .sclr(sclr),
    .in_valid(in_valid), .in_data(in_data),
    .out_valid(v0), .out_data(d0), .occ(o0));
  dsp_pipe_chain #(.WIDTH(W), .DEPTH(2)) u_d2 (
    .clk(clk), .rst(rst), .ce(ce), .sclr(sclr),
    .in_valid(in_valid), .in_data(in_data),
    .out_valid(v2), .out_data(d2), .occ(o2));
  dsp_pipe_chain #(.WIDTH(W), .DEPTH(3)) u_d3 (
    .clk(clk), .rst(rst), .ce(ce), .sclr(sclr),
    .in_valid(in_valid), .in_data(in_data),
    .out_valid(v3), .out_data(d3), .occ(o3));
  dsp_pipe_chain #(.WIDTH(W), .DEPTH(4)) u_d4 (
    .clk(clk), .rst(rst), .ce(ce), .sclr(sclr),
    .in_valid(in_valid), .in_data(in_data),
    .out_valid(v4), .out_data(d4), .occ(o4));

  typedef struct packed {
    logic         v;
    logic [W-1:0] d;
  } samp_t;

  typedef struct packed {
    logic         v;
    logic [W-1:0] d;
    int           occ;
  } exp_t;

  localparam int DEP [3] = '{2, 3, 4};

  samp_t        hist [3][$];
  logic [W-1:0] held [3];
  exp_t         q [3][$];
  int           peak4 = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endfunction

  function automatic void m_clear();
    for (int k = 0; k < 3; k++) begin
      hist[k].delete();
      for (int i = 0; i < DEP[k]; i++) hist[k].push_back('0);
      held[k] = '0;
    end
  endfunction

  function automatic void m_edge(logic c, logic s, logic v, logic [W-1:0] d);
    samp_t old;
    if (s) begin
      m_clear();
    end else if (c) begin
      for (int k = 0; k < 3; k++) begin
        old = hist[k].pop_back();
        if (old.v) held[k] = old.d;
        hist[k].push_front({v, d});
      end
    end
  endfunction

  function automatic exp_t m_out(int k);
    exp_t e;
    samp_t last;
    last  = hist[k][DEP[k]-1];
    e.v   = last.v;
    e.d   = last.v ? last.d : held[k];
    e.occ = 0;
    foreach (hist[k][i]) if (hist[k][i].v) e.occ++;
    return e;
  endfunction

  // Called at posedge+2; leaves time at the next posedge+2.
  task automatic step(logic c, logic s, logic v, logic [W-1:0] d);
    ce = c; sclr = s; in_valid = v; in_data = d;
    #1;
    chk("d0_valid", 64'(v0), 64'(v));
    chk("d0_data", 64'(d0), 64'(d));
    chk("d0_occ", 64'(o0), 64'd0);
    @(posedge clk);
    m_edge(c, s, v, d);
    for (int k = 0; k < 3; k++) q[k].push_back(m_out(k));
    #2;
  endtask

  task automatic zeros_now(string tag);
    chk({tag, "_v2"}, 64'({v2, d2, o2}), 64'd0);
    chk({tag, "_v3"}, 64'({v3, d3, o3}), 64'd0);
    chk({tag, "_v4"}, 64'({v4, d4, o4}), 64'd0);
  endtask

  // Monitor: compares each build's outputs with the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q[0].size() > 0) begin
        e = q[0].pop_front();
        chk("d2_out", 64'({v2, d2}), 64'({e.v, e.d}));
        chk("d2_occ", 64'(o2), 64'(e.occ));
      end
      if (q[1].size() > 0) begin
        e = q[1].pop_front();
        chk("d3_out", 64'({v3, d3}), 64'({e.v, e.d}));
        chk("d3_occ", 64'(o3), 64'(e.occ));
      end
      if (q[2].size() > 0) begin
        e = q[2].pop_front();
        chk("d4_out", 64'({v4, d4}), 64'({e.v, e.d}));
        chk("d4_occ", 64'(o4), 64'(e.occ));
        if (int'(o4) > peak4) peak4 = int'(o4);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic c, s, v;
    m_clear();
    #3 rst = 1'b1;
    #1 zeros_now("reset");
    @(posedge clk);
    #2 rst = 1'b0;

    for (int i = 1; i <= 6; i++) step(1'b1, 1'b0, 1'b1, W'(i));
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, W'(18'h2AAAA + i));
    for (int i = 7; i <= 10; i++) step(1'b1, 1'b0, 1'b1, W'(i));

    step(1'b1, 1'b0, 1'b1, W'(18'h3A));
    step(1'b1, 1'b0, 1'b0, W'(18'hFF));
    step(1'b1, 1'b0, 1'b1, W'(18'h15));
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, W'(18'hFF));

    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, W'(18'h100 + i));
    step(1'b0, 1'b1, 1'b1, W'(18'h0BAD));
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, '0);

    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, W'(18'h200 + i));
    rst = 1'b1;
    #1 zeros_now("async_rst");
    m_clear();
    #1 rst = 1'b0;
    step(1'b1, 1'b0, 1'b1, W'(18'h1234));
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, '0);

    for (int i = 0; i < 400; i++) begin
      c = ($urandom_range(0, 7) != 0);
      s = ($urandom_range(0, 29) == 0);
      v = ($urandom_range(0, 3) != 0);
      step(c, s, v, W'($urandom));
    end

    @(posedge clk);
    #3;
    chk("sb_drained", 64'(q[0].size() + q[1].size() + q[2].size()), 64'd0);
    chk("d4_peak_occ", 64'(peak4), 64'd4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
